// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic {
    S_RUN = 1'b0,
    S_MDU = 1'b1
  } ctrlState_t;

  localparam int DEF_MDU_CYCLES = 32;
  localparam int DEF_CNT_W      = 16;
  localparam int MDU_CNT_W      = 6;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: merges hazard, branch, mul/div and data-memory
// wait conditions into per-stage enables/bubbles, plus stall/flush counters.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = DEF_MDU_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             mdu_req,
  input  logic             dmem_wait,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             pipe_freeze,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_CYCLES - 2);

  ctrlState_t           state, stateNext;
  logic [MDU_CNT_W-1:0] mduCnt, mduCntNext;
  logic                 mduBusyDone;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      mduCnt      <= '0;
      mduBusyDone <= 1'b0;
    end else begin
      state       <= stateNext;
      mduCnt      <= mduCntNext;
      // One-cycle flag so the finishing mul/div does not relaunch itself.
      mduBusyDone <= (state == S_MDU) && (mduCnt == '0);
    end
  end

  always_comb begin
    stateNext    = state;
    mduCntNext   = mduCnt;
    pc_write     = 1'b0;
    ifid_write   = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    mdu_start    = 1'b0;
    mdu_busy     = 1'b0;

    unique case (state)
      S_RUN: begin
        if (dmem_wait) begin
          pipe_freeze = 1'b1;
        end else if (mdu_req && !((mduCnt == '0) && mduBusyDone)) begin
          mdu_start    = 1'b1;
          exmem_bubble = 1'b1;
          stateNext    = S_MDU;
          mduCntNext   = MDU_LOAD;
        end else if (branch_taken) begin
          // The held ID instruction is wrong-path, so the branch beats the hazard.
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hazard_stall) begin
          idex_bubble = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      S_MDU: begin
        mdu_busy = 1'b1;
        if (mduCnt == '0) begin
          stateNext = S_RUN;
        end else begin
          exmem_bubble = 1'b1;
          mduCntNext   = mduCnt - 1'b1;
        end
      end
      default: stateNext = S_RUN;
    endcase

    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      pipe_freeze  = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      mdu_start    = 1'b0;
      mdu_busy     = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) stallCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (!pc_write && !rst),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) flushCounter (
    .clk   (clk),
    .rst   (rst),
    .inc   (ifid_flush && !rst),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl with a short MDU latency and
// narrow counters so saturation is reachable.
module tb_pipe_stall_ctrl;

  localparam int MDU_CYCLES = 4;
  localparam int CNT_W      = 4;

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble,
  //                        exmem_bubble, pipe_freeze, mdu_start, mdu_busy}
  localparam logic [7:0] C_RST    = 8'b0011_1000;
  localparam logic [7:0] C_RUN    = 8'b1100_0000;
  localparam logic [7:0] C_DWAIT  = 8'b0000_0100;
  localparam logic [7:0] C_LAUNCH = 8'b0000_1010;
  localparam logic [7:0] C_MDU    = 8'b0000_1001;
  localparam logic [7:0] C_MDUEND = 8'b0000_0001;
  localparam logic [7:0] C_BRANCH = 8'b1111_0000;
  localparam logic [7:0] C_HAZARD = 8'b0001_0000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hazard_stall = 1'b0;
  logic             branch_taken = 1'b0;
  logic             mdu_req = 1'b0;
  logic             dmem_wait = 1'b0;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic             exmem_bubble, pipe_freeze, mdu_start, mdu_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [7:0]       ctl;

  int checks = 0;
  int errors = 0;

  pipe_stall_ctrl #(.MDU_CYCLES(MDU_CYCLES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .hazard_stall (hazard_stall),
    .branch_taken (branch_taken),
    .mdu_req      (mdu_req),
    .dmem_wait    (dmem_wait),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_bubble (exmem_bubble),
    .pipe_freeze  (pipe_freeze),
    .mdu_start    (mdu_start),
    .mdu_busy     (mdu_busy),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble,
                exmem_bubble, pipe_freeze, mdu_start, mdu_busy};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs mid-cycle and let combinational outputs settle.
  task automatic setIn(input logic h, input logic b, input logic m, input logic d);
    hazard_stall = h;
    branch_taken = b;
    mdu_req      = m;
    dmem_wait    = d;
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    setIn(0, 0, 0, 0);
    checkVal("reset_ctl", 32'(ctl), 32'(C_RST));
    checkVal("reset_stall", 32'(stall_cnt), 0);
    checkVal("reset_flush", 32'(flush_cnt), 0);

    tick();
    rst = 1'b0;
    setIn(0, 0, 0, 0);
    checkVal("idle_ctl", 32'(ctl), 32'(C_RUN));

    // Load-use hazard for one cycle
    tick(); setIn(1, 0, 0, 0);
    checkVal("hazard_ctl", 32'(ctl), 32'(C_HAZARD));
    tick(); setIn(0, 0, 0, 0);
    checkVal("hazard_release", 32'(ctl), 32'(C_RUN));
    checkVal("hazard_stall_cnt", 32'(stall_cnt), 1);

    // Branch together with hazard: branch wins, no stall counted
    tick(); setIn(1, 1, 0, 0);
    checkVal("branch_hazard_ctl", 32'(ctl), 32'(C_BRANCH));
    tick(); setIn(0, 0, 0, 0);
    checkVal("branch_flush_cnt", 32'(flush_cnt), 1);
    checkVal("branch_stall_cnt", 32'(stall_cnt), 1);

    // MDU op, mdu_req held one extra cycle after completion
    tick(); setIn(0, 0, 1, 0);
    checkVal("mdu_launch", 32'(ctl), 32'(C_LAUNCH));
    tick(); checkVal("mdu_busy1", 32'(ctl), 32'(C_MDU));
    tick(); checkVal("mdu_busy2", 32'(ctl), 32'(C_MDU));
    tick(); checkVal("mdu_last", 32'(ctl), 32'(C_MDUEND));
    tick(); checkVal("mdu_no_relaunch", 32'(ctl), 32'(C_RUN));
    checkVal("mdu_stall_cnt", 32'(stall_cnt), 5);
    tick(); setIn(0, 0, 0, 0);
    checkVal("mdu_after", 32'(ctl), 32'(C_RUN));

    // dmem_wait blocks the MDU launch for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick(); setIn(0, 0, 1, 1);
      checkVal($sformatf("dwait_mdu_%0d", i), 32'(ctl), 32'(C_DWAIT));
    end
    tick(); setIn(0, 0, 1, 0);
    checkVal("dwait_then_launch", 32'(ctl), 32'(C_LAUNCH));
    tick(); setIn(0, 0, 0, 0);
    checkVal("dwait_mdu_busy1", 32'(ctl), 32'(C_MDU));
    tick(); tick();
    checkVal("dwait_mdu_last", 32'(ctl), 32'(C_MDUEND));
    tick();
    checkVal("dwait_mdu_done", 32'(ctl), 32'(C_RUN));
    checkVal("dwait_stall_cnt", 32'(stall_cnt), 12);

    // dmem_wait overrides branch and hazard
    setIn(1, 1, 0, 1);
    checkVal("dwait_branch_ctl", 32'(ctl), 32'(C_DWAIT));
    tick(); setIn(0, 0, 0, 0);
    checkVal("dwait_branch_flush", 32'(flush_cnt), 1);
    checkVal("dwait_branch_stall", 32'(stall_cnt), 13);

    // Reset in the middle of an MDU op
    tick(); setIn(0, 0, 1, 0);
    checkVal("rmid_launch", 32'(ctl), 32'(C_LAUNCH));
    tick();
    checkVal("rmid_busy", 32'(ctl), 32'(C_MDU));
    rst = 1'b1;
    #1;
    checkVal("rmid_ctl", 32'(ctl), 32'(C_RST));
    checkVal("rmid_stall", 32'(stall_cnt), 0);
    checkVal("rmid_flush", 32'(flush_cnt), 0);
    tick();
    rst = 1'b0;
    setIn(0, 0, 0, 0);
    checkVal("rmid_post_run", 32'(ctl), 32'(C_RUN));
    setIn(0, 0, 1, 0);
    checkVal("rmid_post_launch", 32'(ctl), 32'(C_LAUNCH));
    tick(); setIn(0, 0, 0, 0);
    tick(); tick(); tick();
    checkVal("rmid_post_idle", 32'(ctl), 32'(C_RUN));
    checkVal("rmid_post_stall", 32'(stall_cnt), 4);

    // Saturation: 20 hazard cycles on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      setIn(1, 0, 0, 0);
      if (i == 0) checkVal("sat_hazard_ctl", 32'(ctl), 32'(C_HAZARD));
      tick();
      if (i == 10) checkVal("sat_reach", 32'(stall_cnt), 15);
    end
    setIn(0, 0, 0, 0);
    checkVal("sat_hold", 32'(stall_cnt), 15);
    checkVal("sat_flush", 32'(flush_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Merges four conditions into one consistent set of per-stage write-enable and bubble controls:
  - combinational load-use/store hazard request from ID;
  - EX-stage taken branch;
  - multi-cycle mul/div (MDU) issue in EX;
  - data-memory wait in MEM.
- Owns the MDU busy countdown and saturating performance counters for stall and flush cycles.

Parameters:
- MDU_CYCLES, 32, EX occupancy of one mul/div operation in cycles; valid range 2..63.
- CNT_W, 16, width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard_stall  in  1  ID hazard request (load-use or store-after-load); 1 = hold IF/ID and bubble ID/EX.
- branch_taken  in  1  EX-stage redirect valid this cycle.
- mdu_req  in  1  instruction in EX is mul/div.
- dmem_wait  in  1  data memory not ready for the MEM-stage access.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  zero the control fields entering ID/EX.
- exmem_bubble  out  1  zero the control fields entering EX/MEM.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- mdu_start  out  1  one-cycle MDU launch pulse.
- mdu_busy  out  1  MDU operation in flight.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0.
- flush_cnt  out  CNT_W  saturating count of ifid_flush cycles.

Behaviour:
- States: S_RUN, S_MDU. Counter: mdu_cnt, 6 bits.
- Outputs are combinational from state and inputs. Counters and state are registered.
- Reset (async, any state, any time):
  - state=S_RUN, mdu_cnt=0, stall_cnt=0, flush_cnt=0.
  - While rst=1: pc_write=0, ifid_write=0, pipe_freeze=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, mdu_start=0, mdu_busy=0.
  - An MDU operation in progress is abandoned.
- S_RUN: evaluate in priority order; the first true condition wins.
  1. dmem_wait=1:
     - pc_write=0, ifid_write=0, pipe_freeze=1, no bubbles.
     - Stay in S_RUN. branch_taken, mdu_req and hazard_stall are ignored this cycle.
  2. mdu_req=1 and not (mdu_cnt==0 and mdu_busy_done):
     - mdu_start=1, pc_write=0, ifid_write=0, idex_bubble=0.
     - ID/EX held via its own write = ifid_write.
     - exmem_bubble=1.
     - Next state S_MDU; mdu_cnt <= MDU_CYCLES-2.
  3. branch_taken=1:
     - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
     - Branch wins over hazard_stall because the stalled ID instruction is wrong-path.
  4. hazard_stall=1:
     - pc_write=0, ifid_write=0, idex_bubble=1.
  5. Otherwise: pc_write=1, ifid_write=1, all bubbles/flush/freeze 0.
- mdu_busy_done:
  - Internal flag, set on the S_MDU->S_RUN transition and cleared after one cycle.
  - Prevents the same mul/div (still asserting mdu_req for one cycle) from relaunching.
- S_MDU:
  - mdu_busy=1, pc_write=0, ifid_write=0, exmem_bubble=1.
  - dmem_wait, branch_taken and hazard_stall are ignored; MEM only holds bubbles here.
  - mdu_cnt decrements each cycle.
  - At mdu_cnt==0: exmem_bubble=0 so the result latches into EX/MEM, and the next state is S_RUN with mdu_busy_done=1.
  - Total front-end stall is exactly MDU_CYCLES cycles (launch cycle + MDU_CYCLES-1 in S_MDU).
- Counters:
  - stall_cnt increments every cycle with pc_write=0 and rst=0.
  - flush_cnt increments every cycle with ifid_flush=1 and rst=0.
  - Both saturate at all-ones; no wrap.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {S_RUN, S_MDU};
  - default MDU_CYCLES constant;
  - CNT_W default.
- One natural sub-module: sat_counter (CNT_W-bit, inc enable, async reset), instantiated twice.

Test Plan:
- Reset mid-MDU: assert rst in cycle 5 of an MDU op -> same cycle pc_write=0, ifid_flush=1, mdu_busy=0. After release: state S_RUN, counters 0.
- Load-use: hazard_stall=1 for 1 cycle -> pc_write=0, ifid_write=0, idex_bubble=1 for exactly 1 cycle; stall_cnt=1.
- Branch+hazard: branch_taken=1 and hazard_stall=1 together -> pc_write=1, ifid_flush=1, idex_bubble=1; flush_cnt=1, stall_cnt=0.
- MDU (MDU_CYCLES=4): mdu_req=1 -> mdu_start pulses once; pc_write=0 for 4 cycles; exmem_bubble=1 for 3 cycles then 0; no second mdu_start while mdu_req stays high 1 extra cycle.
- dmem_wait with mdu_req: dmem_wait=1 for 3 cycles with mdu_req=1 -> pipe_freeze=1 for 3 cycles with no mdu_start; mdu_start in cycle 4.
- Saturation (CNT_W=4): 20 consecutive hazard cycles -> stall_cnt holds 15.
